// File: rtl/video_window_flush_ctrl.sv
// ---------------------------------------------------------------------------
// video_window_flush_ctrl
//
// Sits in front of a vertical windowing stage (WIN_SIZE lines tall). Normal
// traffic is forwarded with one register stage. At the end of a frame it
// holds off upstream and appends WIN_SIZE/2 synthetic all-zero lines, each
// preceded by GAP_CYCLES idle cycles. These lines push the last real lines
// out of the window. Each synthetic line has the length and last-beat mask
// of the last real line that was seen.
//
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   px_data_i / px_data_val_i     packed pixels (pixel 0 in LSBs), per-pixel valid
//   line/frame start/end _i       markers, qualified by a present beat
//   ready_o                       upstream may present beats while high
//   px_data_o ... frame_end_o     registered stream to the windowing stage
//   flush_busy_o                  high while gap/flush lines are generated
//   overflow_o                    sticky, a beat arrived while ready_o was low
// ---------------------------------------------------------------------------
module video_window_flush_ctrl #(
    parameter int PX_WIDTH      = 12,
    parameter int PX_PER_CLK    = 4,
    parameter int WIN_SIZE      = 3,
    parameter int MAX_LINE_SIZE = 4112,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
    input  logic [PX_PER_CLK-1:0]          px_data_val_i,
    input  logic                           line_start_i,
    input  logic                           line_end_i,
    input  logic                           frame_start_i,
    input  logic                           frame_end_i,
    output logic                           ready_o,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           flush_busy_o,
    output logic                           overflow_o
);
    localparam int DW          = PX_PER_CLK*PX_WIDTH;
    localparam int FLUSH_LINES = WIN_SIZE/2;
    localparam int MAX_WORDS   = MAX_LINE_SIZE/PX_PER_CLK;
    localparam int WC_W        = $clog2(MAX_WORDS+1);
    localparam int GC_W        = $clog2(GAP_CYCLES+1);
    // +2 keeps the width non-zero when no flush lines are configured
    localparam int FL_W        = $clog2(FLUSH_LINES+2);

    localparam logic [WC_W-1:0] MAX_WORDS_C   = WC_W'(MAX_WORDS);
    localparam logic [GC_W-1:0] GAP_C         = GC_W'(GAP_CYCLES);
    localparam logic [FL_W-1:0] FLUSH_LINES_C = FL_W'(FLUSH_LINES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PASS  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WC_W-1:0]       wcnt_q, wcnt_d;
    logic [WC_W-1:0]       line_words_q, line_words_d;
    logic [PX_PER_CLK-1:0] last_mask_q, last_mask_d;
    logic                  line_known_q, line_known_d;
    logic [GC_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [WC_W-1:0]       flush_word_q, flush_word_d;
    logic [FL_W-1:0]       flush_line_q, flush_line_d;
    logic                  overflow_q, overflow_d;
    logic [DW-1:0]         px_data_q, px_data_d;
    logic [PX_PER_CLK-1:0] px_val_q, px_val_d;
    logic                  ls_q, ls_d, le_q, le_d, fs_q, fs_d, fe_q, fe_d;

    logic                  beat, ready, take, last_word, lk_next;
    logic [WC_W-1:0]       wc_next;
    logic [FL_W-1:0]       flush_line_nxt;

    always_comb begin
        beat  = |px_data_val_i;
        ready = (state_q == S_IDLE) || (state_q == S_PASS);
        take  = beat && ready;

        state_d      = state_q;
        wcnt_d       = wcnt_q;
        line_words_d = line_words_q;
        last_mask_d  = last_mask_q;
        line_known_d = line_known_q;
        gap_cnt_d    = gap_cnt_q;
        flush_word_d = flush_word_q;
        flush_line_d = flush_line_q;
        overflow_d   = overflow_q | (beat & ~ready);
        px_data_d    = '0;
        px_val_d     = '0;
        ls_d         = 1'b0;
        le_d         = 1'b0;
        fs_d         = 1'b0;
        fe_d         = 1'b0;

        // A new line (or a new frame) restarts the count at this beat; the
        // count saturates rather than wrapping on over-long lines.
        if (line_start_i || frame_start_i)  wc_next = WC_W'(1);
        else if (wcnt_q == MAX_WORDS_C)     wc_next = wcnt_q;
        else                                wc_next = wcnt_q + 1'b1;
        lk_next = (frame_start_i ? 1'b0 : line_known_q) | line_end_i;

        last_word      = (flush_word_q == line_words_q - 1'b1);
        flush_line_nxt = flush_line_q + 1'b1;

        case (state_q)
            S_IDLE, S_PASS: begin
                if (take) begin
                    wcnt_d       = wc_next;
                    line_known_d = lk_next;
                    if (line_end_i) begin
                        line_words_d = wc_next;
                        last_mask_d  = px_data_val_i;
                    end
                    px_data_d = px_data_i;
                    px_val_d  = px_data_val_i;
                    ls_d      = line_start_i;
                    le_d      = line_end_i;
                    fs_d      = frame_start_i;
                    fe_d      = frame_end_i;
                    if (frame_start_i) begin
                        state_d = S_PASS;
                    end else if (state_q == S_PASS && frame_end_i) begin
                        // Frame end is withheld and re-emitted on the last
                        // synthetic line instead.
                        if (FLUSH_LINES > 0 && lk_next) begin
                            fe_d         = 1'b0;
                            state_d      = S_GAP;
                            gap_cnt_d    = GAP_C;
                            flush_line_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GC_W'(1)) begin
                    state_d      = S_FLUSH;
                    flush_word_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin  // S_FLUSH
                px_val_d     = last_word ? last_mask_q : '1;
                ls_d         = (flush_word_q == '0);
                le_d         = last_word;
                flush_word_d = flush_word_q + 1'b1;
                if (last_word) begin
                    flush_line_d = flush_line_nxt;
                    if (flush_line_nxt < FLUSH_LINES_C) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_C;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            line_words_q <= '0;
            last_mask_q  <= '1;
            line_known_q <= 1'b0;
            gap_cnt_q    <= '0;
            flush_word_q <= '0;
            flush_line_q <= '0;
            overflow_q   <= 1'b0;
            px_data_q    <= '0;
            px_val_q     <= '0;
            ls_q         <= 1'b0;
            le_q         <= 1'b0;
            fs_q         <= 1'b0;
            fe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            line_words_q <= line_words_d;
            last_mask_q  <= last_mask_d;
            line_known_q <= line_known_d;
            gap_cnt_q    <= gap_cnt_d;
            flush_word_q <= flush_word_d;
            flush_line_q <= flush_line_d;
            overflow_q   <= overflow_d;
            px_data_q    <= px_data_d;
            px_val_q     <= px_val_d;
            ls_q         <= ls_d;
            le_q         <= le_d;
            fs_q         <= fs_d;
            fe_q         <= fe_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE) || (state_q == S_PASS);
    assign flush_busy_o  = (state_q == S_GAP) || (state_q == S_FLUSH);
    assign overflow_o    = overflow_q;
    assign px_data_o     = px_data_q;
    assign px_data_val_o = px_val_q;
    assign line_start_o  = ls_q;
    assign line_end_o    = le_q;
    assign frame_start_o = fs_q;
    assign frame_end_o   = fe_q;

endmodule

// File: tb/tb_video_window_flush_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for video_window_flush_ctrl. Three instances share clock and reset:
//   0: defaults (WIN_SIZE 3, GAP 16)  1: WIN_SIZE 5, GAP 2  2: WIN_SIZE 1
// Only one instance is driven at a time, so a single scoreboard queue holds
// the expected output beats, each with the idle-cycle gap expected before it
// (-1 = don't care).
// ---------------------------------------------------------------------------
module tb_video_window_flush_ctrl;
    localparam int PW   = 12;
    localparam int PPC  = 4;
    localparam int DW   = PW*PPC;
    localparam int ND   = 3;
    localparam int MAXW = 4112/PPC;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    v;
        logic          ls, le, fs, fe;
    } beat_t;

    typedef struct {
        beat_t b;
        int    gap;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din  [ND];
    logic [3:0]    vin  [ND];
    logic [DW-1:0] dout [ND];
    logic [3:0]    vout [ND];
    logic [ND-1:0] ls_i, le_i, fs_i, fe_i, ls_o, le_o, fs_o, fe_o;
    logic [ND-1:0] rdy, busy, ovf;

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        video_window_flush_ctrl #(
            .PX_WIDTH      (PW),
            .PX_PER_CLK    (PPC),
            .WIN_SIZE      (k == 1 ? 5 : (k == 2 ? 1 : 3)),
            .MAX_LINE_SIZE (4112),
            .GAP_CYCLES    (k == 1 ? 2 : 16)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .px_data_i     (din[k]),
            .px_data_val_i (vin[k]),
            .line_start_i  (ls_i[k]),
            .line_end_i    (le_i[k]),
            .frame_start_i (fs_i[k]),
            .frame_end_i   (fe_i[k]),
            .ready_o       (rdy[k]),
            .px_data_o     (dout[k]),
            .px_data_val_o (vout[k]),
            .line_start_o  (ls_o[k]),
            .line_end_o    (le_o[k]),
            .frame_start_o (fs_o[k]),
            .frame_end_o   (fe_o[k]),
            .flush_busy_o  (busy[k]),
            .overflow_o    (ovf[k])
        );
    end

    int  checks = 0;
    int  errors = 0;
    sb_t exp_q [$];
    int  idle_cnt [ND];
    int  seen [ND];
    sb_t mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int fl_of(input int k);
        return (k == 1) ? 2 : ((k == 2) ? 0 : 1);
    endfunction

    function automatic int gap_of(input int k);
        return (k == 1) ? 2 : 16;
    endfunction

    // Output monitor: every present output beat must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < ND; k++) begin
                if (vout[k] != '0) begin
                    chk($sformatf("sb_nonempty%0d", k), 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("beat%0d", k),
                            {dout[k], vout[k], ls_o[k], le_o[k], fs_o[k], fe_o[k]}, mon_e.b);
                        if (mon_e.gap >= 0)
                            chk($sformatf("gap%0d", k), 64'(idle_cnt[k]), 64'(mon_e.gap));
                    end
                    idle_cnt[k] = 0;
                    seen[k]++;
                end else begin
                    idle_cnt[k]++;
                end
            end
            chk("busy_win1", busy[2], 0);
        end
    end

    task automatic zero_inputs();
        for (int k = 0; k < ND; k++) begin
            din[k] = '0;
            vin[k] = '0;
        end
        ls_i = '0; le_i = '0; fs_i = '0; fe_i = '0;
    endtask

    task automatic drive(input int k, input logic [DW-1:0] d, input logic [3:0] v,
                         input logic ls, input logic le, input logic fs, input logic fe);
        @(posedge clk); #1;
        zero_inputs();
        din[k] = d; vin[k] = v;
        ls_i[k] = ls; le_i[k] = le; fs_i[k] = fs; fe_i[k] = fe;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            zero_inputs();
        end
    endtask

    task automatic push(input beat_t b, input int gap);
        sb_t s;
        s.b = b;
        s.gap = gap;
        exp_q.push_back(s);
    endtask

    // Drives nl lines of nw words; the last beat of each line carries lm.
    // Pushes the forwarded beats and, when fe_en, the synthetic flush lines.
    task automatic send_frame(input int k, input int nl, input int nw,
                              input logic [3:0] lm, input bit fe_en);
        beat_t b;
        int    fl, ws;
        bit    lastb;
        fl = fe_en ? fl_of(k) : 0;
        for (int l = 0; l < nl; l++) begin
            for (int w = 0; w < nw; w++) begin
                lastb = (l == nl-1) && (w == nw-1);
                b.d  = {16'($urandom), 32'($urandom)};
                b.v  = (w == nw-1) ? lm : 4'hF;
                b.ls = (w == 0);
                b.le = (w == nw-1);
                b.fs = (l == 0) && (w == 0);
                b.fe = fe_en && lastb && (fl == 0);
                push(b, (l == 0 && w == 0) ? -1 : 0);
                drive(k, b.d, b.v, b.ls, b.le, b.fs, fe_en && lastb);
            end
        end
        ws = (nw > MAXW) ? MAXW : nw;
        for (int fli = 0; fli < fl; fli++) begin
            for (int w = 0; w < ws; w++) begin
                b.d  = '0;
                b.v  = (w == ws-1) ? lm : 4'hF;
                b.ls = (w == 0);
                b.le = (w == ws-1);
                b.fs = 1'b0;
                b.fe = (fli == fl-1) && (w == ws-1);
                push(b, (w == 0) ? gap_of(k) : 0);
            end
        end
        idle(1);
        if (fe_en) begin
            @(negedge clk);
            chk("ready_after_fe", rdy[k], (fl == 0) ? 1 : 0);
            chk("busy_after_fe", busy[k], (fl != 0) ? 1 : 0);
        end
    endtask

    task automatic wait_drain(input int k);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_in_time", 64'(t < 5000), 64'd1);
        @(negedge clk);
        chk("ready_after_flush", rdy[k], 1);
        chk("idle_not_busy", busy[k], 0);
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < ND; k++) begin
            chk("rst_stream", {dout[k], vout[k], ls_o[k], le_o[k], fs_o[k], fe_o[k]}, '0);
            chk("rst_ready", rdy[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_ovf", ovf[k], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        beat_t b;
        int    s0, t;
        zero_inputs();
        for (int k = 0; k < ND; k++) begin
            idle_cnt[k] = 0;
            seen[k] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // two 8-word lines, one flush line after a 16-cycle gap
        send_frame(0, 2, 8, 4'hF, 1);
        wait_drain(0);

        // WIN_SIZE 5, GAP 2: two 3-word flush lines, last mask 4'h3
        send_frame(1, 2, 3, 4'h3, 1);
        wait_drain(1);

        // WIN_SIZE 1: frame end passes straight through
        send_frame(2, 2, 5, 4'h1, 1);
        wait_drain(2);

        // 1-word lines: flush beat carries both line markers
        send_frame(0, 3, 1, 4'h7, 1);
        wait_drain(0);

        // stray beat outside a frame is forwarded without state change
        b.d = {16'hBEEF, 32'($urandom)}; b.v = 4'h9;
        b.ls = 1'b0; b.le = 1'b0; b.fs = 1'b0; b.fe = 1'b0;
        push(b, -1);
        drive(0, b.d, b.v, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        wait_drain(0);

        // missing frame end: second frame start restarts, flush uses new line
        send_frame(0, 2, 4, 4'hF, 0);
        send_frame(0, 2, 6, 4'h3, 1);
        wait_drain(0);

        // beat during GAP is dropped and sets the sticky overflow
        chk("ovf_clear", ovf[0], 0);
        send_frame(0, 2, 2, 4'hF, 1);
        drive(0, {16'hDEAD, 32'h12345678}, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        chk("ovf_set", ovf[0], 1);
        wait_drain(0);
        idle(5);
        @(negedge clk);
        chk("ovf_sticky", ovf[0], 1);

        // over-long lines: flush length saturates at MAX_LINE_SIZE/PX_PER_CLK
        send_frame(0, 2, MAXW+2, 4'h5, 1);
        wait_drain(0);

        // reset pulsed on the 3rd flush beat
        s0 = seen[0];
        send_frame(0, 2, 6, 4'hF, 1);
        t = 0;
        while (seen[0] < s0 + 14 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("flush_start_in_time", 64'(t < 200), 64'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(25);
        @(negedge clk);
        chk("no_flush_after_rst", 64'(exp_q.size()), 64'd0);
        chk("ready_after_rst", rdy[0], 1);
        send_frame(0, 2, 4, 4'hC, 1);
        wait_drain(0);

        idle(3);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_window_flush_ctrl.md
VIDEO_WINDOW_FLUSH_CTRL -- requirements
Module: video_window_flush_ctrl

Interface
REQ-001 Parameter PX_WIDTH, default 12, bits per pixel.
REQ-002 Parameter PX_PER_CLK, default 4, pixels per beat.
REQ-003 Parameter WIN_SIZE, default 3, odd window height of downstream windowing stage; FLUSH_LINES = WIN_SIZE/2.
REQ-004 Parameter MAX_LINE_SIZE, default 4112, max pixels per line; word counter width = $clog2(MAX_LINE_SIZE/PX_PER_CLK+1).
REQ-005 Parameter GAP_CYCLES, default 16, idle cycles inserted before each flush line (minimum 1).
REQ-006 clk_i  input  1  single clock, all logic rising-edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 px_data_i  input  PX_PER_CLK*PX_WIDTH  input pixels, packed, pixel 0 in LSBs.
REQ-009 px_data_val_i  input  PX_PER_CLK  per-pixel valid; beat present when any bit set.
REQ-010 line_start_i / line_end_i / frame_start_i / frame_end_i  input  1 each  markers, qualified by a present beat.
REQ-011 ready_o  output  1  upstream may present beats only while high.
REQ-012 px_data_o, px_data_val_o, line_start_o, line_end_o, frame_start_o, frame_end_o  output  same widths as inputs  stream to windowing stage.
REQ-013 flush_busy_o  output  1  high in GAP and FLUSH states.
REQ-014 overflow_o  output  1  sticky: beat presented while ready_o low.

Function
REQ-015 FSM states IDLE, PASS, GAP, FLUSH; reset state IDLE.
REQ-016 IDLE: present beat with frame_start_i -> PASS; beats without frame_start_i in IDLE are forwarded unchanged, no state change.
REQ-017 PASS/IDLE forwarding: all outputs registered, latency exactly 1 cycle, data/markers unmodified except frame_end (REQ-020).
REQ-018 Line length: word counter cleared on line_start_i beat, incremented per present beat; on line_end_i beat, line_words latched (inclusive count) and last-beat valid mask latched as last_mask; line_start and line_end on one beat gives line_words = 1.
REQ-019 line_known flag set on first latched line_end_i in a frame, cleared on frame_start_i beat.
REQ-020 PASS, frame_end_i beat, FLUSH_LINES > 0 and line_known: beat forwarded with frame_end_o = 0, next state GAP; otherwise frame_end_o forwarded and next state IDLE.
REQ-021 ready_o = 1 in IDLE/PASS, 0 in GAP/FLUSH; ready_o drops the cycle after the frame_end_i beat.
REQ-022 GAP: gap counter loaded GAP_CYCLES, decremented per cycle, outputs invalid (val = 0, markers 0); at count 1 -> FLUSH.
REQ-023 FLUSH: emits line_words consecutive beats, px_data_o = 0, px_data_val_o = all ones except last beat = last_mask; line_start_o on first beat, line_end_o on last beat; 1-word line: both on same beat.
REQ-024 Flush line counter counts emitted flush lines; after line end: if lines < FLUSH_LINES -> GAP, else frame_end_o asserted on that last beat and next state IDLE.
REQ-025 frame_start_o never asserted on flush beats.
REQ-026 Beat presented while ready_o = 0: dropped, overflow_o set, cleared only by reset.
REQ-027 Beat with frame_start_i in PASS (missing frame_end): treated as new frame, counters/line_known cleared, no flush.
REQ-028 Line words above MAX_LINE_SIZE/PX_PER_CLK: counter saturates.

Reset
REQ-029 During rst_i: state IDLE, all counters 0, line_known 0, last_mask all ones, ready_o 1, flush_busy_o 0, overflow_o 0, all stream outputs 0.
REQ-030 Reset deasserted mid-flush: no further flush beats; block resumes in IDLE.

Verification
REQ-031 PX_PER_CLK=4, WIN_SIZE=3, 2 lines of 8 words, frame_end on last beat -> frame_end_o 0 on that beat, ready_o low, 16 idle cycles, 8 zero beats val=4'hF with line_start/line_end, frame_end_o on 8th, ready_o high next cycle.
REQ-032 WIN_SIZE=5, GAP_CYCLES=2, line 3 words, last mask 4'h3 -> two flush lines each 2 idle + 3 beats, last beat val 4'h3, frame_end_o only on second line end.
REQ-033 WIN_SIZE=1 -> frame_end passes through at 1-cycle latency, flush_busy_o never high.
REQ-034 Beat presented during GAP -> beat absent from output, overflow_o = 1 persists until reset.
REQ-035 1-word lines -> each flush beat has line_start_o and line_end_o both high.
REQ-036 rst_i pulsed on 3rd flush beat -> all outputs 0 during reset, ready_o = 1, next frame passes normally.
